// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - bit-serial a - b - b_in controller
// One full-subtractor cell is reused per bit, LSB first; the result is published only when all bits are done.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic cell_x, cell_y, cell_bi;
  logic cell_d, cell_bo;

  always_comb begin
    cell_x  = sa_q[0];
    cell_y  = sb_q[0];
    cell_bi = br_q;
    cell_d  = cell_x ^ cell_y ^ cell_bi;
    cell_bo = (~cell_x & (cell_y | cell_bi)) | (cell_y & cell_bi);
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    diff_d   = diff_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = b_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        sr_d  = {cell_d, sr_q[WIDTH-1:1]};
        br_d  = cell_bo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Publish the fully assembled word in one step so partial results never reach diff.
          diff_d   = {cell_d, sr_q[WIDTH-1:1]};
          borrow_d = cell_bo;
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb/tb_serial_subtractor_ctrl.sv - self-checking bench for serial_subtractor_ctrl
// Results are scoreboarded: expected {borrow, diff} is queued on start and popped on each done pulse.
module tb_serial_subtractor_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        bin8 = 1'b0;
  logic        busy8, done8, bo8;
  logic [7:0]  diff8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        bin16 = 1'b0;
  logic        busy16, done16, bo16;
  logic [15:0] diff16;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0]  q8[$];
  logic [16:0] q16[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t tbl[8];

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .b_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .b_in(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL done8_unexpected: got done pulse expected none");
      end else begin
        logic [8:0] e;
        e = q8.pop_front();
        chk("diff8", 32'(diff8), 32'(e[7:0]));
        chk("borrow8", 32'(bo8), 32'(e[8]));
      end
    end
  end

  always @(negedge clk) begin
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL done16_unexpected: got done pulse expected none");
      end else begin
        logic [16:0] e;
        e = q16.pop_front();
        chk("diff16", 32'(diff16), 32'(e[15:0]));
        chk("borrow16", 32'(bo16), 32'(e[16]));
      end
    end
  end

  task automatic wait_done8();
    int n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done8 !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL done8_timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic wait_done16();
    int n = 0;
    while (done16 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done16 !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL done16_timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi, input logic [8:0] exp);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    q8.push_back(exp);
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();
    @(negedge clk);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bi, input logic [16:0] exp);
    @(negedge clk);
    a16 = a; b16 = b; bin16 = bi; start16 = 1'b1;
    q16.push_back(exp);
    @(negedge clk);
    start16 = 1'b0;
    wait_done16();
    @(negedge clk);
  endtask

  initial begin
    int bc, dn, di, nd;
    int t[3];
    int cyc;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    tbl[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    tbl[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
    tbl[4] = '{8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
    tbl[6] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    tbl[7] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_diff8", 32'(diff8), 32'd0);
    chk("rst_borrow8", 32'(bo8), 32'd0);
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_diff16", 32'(diff16), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      op8(tbl[i].a, tbl[i].b, tbl[i].bi, {tbl[i].bo, tbl[i].d});

    // Ignore-while-busy; previous result 0x01/0 must hold until the final RUN edge.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h01E);
    @(negedge clk);
    start8 = 1'b0;
    dn = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      if (done8 === 1'b1) dn++;
      if (k < 8) begin
        chk("hold_diff8", 32'(diff8), 32'h01);
        chk("hold_borrow8", 32'(bo8), 32'd0);
      end
    end
    chk("ignore_done_count", 32'(dn), 32'd1);

    // Latency: busy for 9 cycles, done on the 9th cycle after accept.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h01E);
    @(negedge clk);
    start8 = 1'b0;
    bc = 0; dn = 0; di = -1;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge clk);
      if (busy8 === 1'b1) bc++;
      if (done8 === 1'b1) begin
        dn++;
        di = k;
      end
    end
    chk("lat_busy_cycles", 32'(bc), 32'd9);
    chk("lat_done_count", 32'(dn), 32'd1);
    chk("lat_done_index", 32'(di), 32'd8);

    // Reset in the middle of RUN abandons the operation.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy8", 32'(busy8), 32'd0);
    chk("midrst_done8", 32'(done8), 32'd0);
    chk("midrst_diff8", 32'(diff8), 32'd0);
    chk("midrst_borrow8", 32'(bo8), 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    op8(8'h03, 8'h05, 1'b0, 9'h1FE);

    // start held high: done pulses exactly WIDTH+2 cycles apart.
    @(negedge clk);
    a8 = 8'h37; b8 = 8'h42; bin8 = 1'b1; start8 = 1'b1;
    repeat (3) q8.push_back(9'h1F4);
    nd = 0; cyc = 0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    while (nd < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done8 === 1'b1) begin
        t[nd] = cyc;
        nd++;
      end
    end
    start8 = 1'b0;
    chk("b2b_done_count", 32'(nd), 32'd3);
    chk("b2b_spacing_1", 32'(t[1] - t[0]), 32'd10);
    chk("b2b_spacing_2", 32'(t[2] - t[1]), 32'd10);
    repeat (2) @(negedge clk);

    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [7:0] ra, rb;
          logic rbi;
          logic [8:0] m;
          ra = 8'($urandom_range(0, 255));
          rb = 8'($urandom_range(0, 255));
          rbi = 1'($urandom_range(0, 1));
          m = {1'b0, ra} - {1'b0, rb} - {8'b0, rbi};
          op8(ra, rb, rbi, m);
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [15:0] ra, rb;
          logic rbi;
          logic [16:0] m;
          ra = 16'($urandom_range(0, 65535));
          rb = 16'($urandom_range(0, 65535));
          rbi = 1'($urandom_range(0, 1));
          m = {1'b0, ra} - {1'b0, rb} - {16'b0, rbi};
          op16(ra, rb, rbi, m);
        end
      end
    join

    repeat (3) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q16_drained", 32'(q16.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
